rs232tx_buffered: RTL and testbench

RS232TX_BUFFERED -- requirements
Module: rs232tx_buffered

---
 rtl/rs232tx_buffered.sv | 165 ++++++++++++++++
 tb/tb_rs232tx_buffered.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs232tx_buffered.sv
// Buffered RS-232 transmitter: a power-of-two FIFO feeding a start/data/parity/stop
// frame engine. Bit period is FREQUENCY/BPS clocks; the line is driven from a flop.
module rs232tx_buffered #(
  parameter int FREQUENCY = 50_000_000,
  parameter int BPS       = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [DATA_BITS-1:0]         d,
  input  logic                         we,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         overflow,
  output logic                         serial_out
);

  localparam int DIV = FREQUENCY / BPS;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;
  logic                 serial_out_q, serial_out_d;
  logic                 wr_en, pop, baud_end;

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pop          = 1'b0;
    // full is judged on the pre-edge occupancy, so a same-edge pop never frees room
    wr_en        = we && (count_q != DEPTH_C);
    overflow_d   = overflow_q | (we & (count_q == DEPTH_C));
    baud_end     = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + BW'(1);
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = 4'd0;
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = 4'd0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (baud_end) state_d = STOP;
      end
      STOP: begin
        if (baud_end) begin
          if (bit_q == STOP_LAST) begin
            // chain straight into the next frame so queued bytes go out gap-free
            if (count_q != '0) pop = 1'b1;
            else               state_d = IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d  = START;
      baud_d   = '0;
      bit_d    = 4'd0;
      shift_d  = mem[rd_ptr_q];
      parity_d = (PARITY == 1) ? ~(^mem[rd_ptr_q]) : ^mem[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);

    count_d = count_q + CW'(wr_en) - CW'(pop);

    case (state_q)
      START:   serial_out_d = 1'b0;
      DATA:    serial_out_d = shift_q[0];
      PAR:     serial_out_d = parity_q;
      default: serial_out_d = 1'b1;
    endcase

    // the line lags the state by one flop, so stay busy through that last cycle too
    busy_d = (state_d != IDLE) || (count_d != '0) || (state_q != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= 4'd0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      serial_out_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      serial_out_q <= serial_out_d;
    end
  end

  // storage has no reset; emptiness is tracked by the pointers and count alone
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= d;
  end

  assign full       = (count_q == DEPTH_C);
  assign count      = count_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign serial_out = serial_out_q;

endmodule

// File: tb/tb_rs232tx_buffered.sv
// Directed bench for rs232tx_buffered: five configurations share one clock and reset;
// each line is checked cycle by cycle against a frame model, plus a random stream phase.
module tb_rs232tx_buffered;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] we_v;
  logic [7:0] dbus;
  logic [4:0] so_v, busy_v, ovf_v, full_v;
  logic [4:0] cnt0, cnt1, cnt2, cnt4;
  logic [2:0] cnt3;

  int checks = 0;
  int errors = 0;

  logic [7:0] wr_data [8];
  logic [7:0] fr_data [8];
  int         cnt_exp [8];

  int         m_cnt, m_edge, m_free;
  bit         m_drop;
  bit         rx_en = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] rx_q  [$];

  always #5 clk = ~clk;

  rs232tx_buffered #(.FREQUENCY(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .DEPTH(16)) u0 (
    .clock(clk), .reset_n(reset_n), .d(dbus), .we(we_v[0]), .full(full_v[0]),
    .count(cnt0), .busy(busy_v[0]), .overflow(ovf_v[0]), .serial_out(so_v[0]));

  rs232tx_buffered #(.FREQUENCY(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .DEPTH(16)) u1 (
    .clock(clk), .reset_n(reset_n), .d(dbus), .we(we_v[1]), .full(full_v[1]),
    .count(cnt1), .busy(busy_v[1]), .overflow(ovf_v[1]), .serial_out(so_v[1]));

  rs232tx_buffered #(.FREQUENCY(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(1),
                     .STOP_BITS(1), .DEPTH(16)) u2 (
    .clock(clk), .reset_n(reset_n), .d(dbus), .we(we_v[2]), .full(full_v[2]),
    .count(cnt2), .busy(busy_v[2]), .overflow(ovf_v[2]), .serial_out(so_v[2]));

  rs232tx_buffered #(.FREQUENCY(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .DEPTH(4)) u3 (
    .clock(clk), .reset_n(reset_n), .d(dbus), .we(we_v[3]), .full(full_v[3]),
    .count(cnt3), .busy(busy_v[3]), .overflow(ovf_v[3]), .serial_out(so_v[3]));

  rs232tx_buffered #(.FREQUENCY(1_000_000), .BPS(100_000), .DATA_BITS(7), .PARITY(1),
                     .STOP_BITS(2), .DEPTH(16)) u4 (
    .clock(clk), .reset_n(reset_n), .d(dbus[6:0]), .we(we_v[4]), .full(full_v[4]),
    .count(cnt4), .busy(busy_v[4]), .overflow(ovf_v[4]), .serial_out(so_v[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [4:0] cnt_of(input int idx);
    case (idx)
      0:       return cnt0;
      1:       return cnt1;
      2:       return cnt2;
      3:       return {2'b00, cnt3};
      default: return cnt4;
    endcase
  endfunction

  // Expected line level k cycles into a frame with a 10-cycle bit period.
  function automatic logic exp_bit(input int k, input int dat, input int nb,
                                   input int par, input int ns);
    int b;
    int ones;
    b    = k / 10;
    ones = 0;
    if (b == 0) return 1'b0;
    if (b <= nb) return ((dat >> (b - 1)) & 1) == 1;
    if (par != 0 && b == nb + 1) begin
      for (int i = 0; i < nb; i++) ones += (dat >> i) & 1;
      return (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
    end
    return (ns > 0);
  endfunction

  // Writes wr_data[0..nwr-1] on edges 0..nwr-1, then checks every cycle n (after edge n).
  task automatic run_frames(input string tag, input int idx, input int nwr, input int nfr,
                            input int nb, input int par, input int ns, input int depth,
                            input int ncnt, input int ovf_at, input int ncyc);
    int   len;
    int   k;
    logic e;
    len = 10 * (1 + nb + ((par != 0) ? 1 : 0) + ns);
    @(negedge clk);
    dbus      = wr_data[0];
    we_v[idx] = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      k = n - 2;
      e = 1'b1;
      if (k >= 0 && (k / len) < nfr) e = exp_bit(k % len, int'(fr_data[k / len]), nb, par, ns);
      chk($sformatf("%s_line@%0d", tag, n), so_v[idx], e);
      chk($sformatf("%s_busy@%0d", tag, n), busy_v[idx], (n < 2 + nfr * len));
      chk($sformatf("%s_ovf@%0d", tag, n), ovf_v[idx], (n >= ovf_at));
      if (n < ncnt) begin
        chk($sformatf("%s_count@%0d", tag, n), cnt_of(idx), cnt_exp[n]);
        chk($sformatf("%s_full@%0d", tag, n), full_v[idx], (cnt_exp[n] == depth));
      end
      if (n + 1 < nwr) dbus = wr_data[n + 1];
      else             we_v[idx] = 1'b0;
    end
  endtask

  // One edge of random traffic on u0, mirrored by an occupancy/pop-timing model.
  task automatic rnd_step(input logic w, input logic [7:0] v);
    bit acc;
    bit pop;
    @(negedge clk);
    we_v[0] = w;
    dbus    = v;
    acc = w && (m_cnt < 16);
    pop = (m_cnt > 0) && (m_edge >= m_free);
    if (pop) m_free = m_edge + 100;
    if (acc) exp_q.push_back(v);
    if (w && !acc) m_drop = 1'b1;
    m_cnt  = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
    m_edge = m_edge + 1;
  endtask

  // Mid-bit sampler of u0's line, active only during the random phase.
  initial begin : rx_proc
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_en && prev && !so_v[0]) begin
        repeat (5) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (10) @(negedge clk);
          b[j] = so_v[0];
        end
        repeat (10) @(negedge clk);
        chk("rx_stop", so_v[0], 1'b1);
        rx_q.push_back(b);
        prev = 1'b1;
      end else begin
        prev = so_v[0];
      end
    end
  end

  initial begin
    int gap;
    int nb_cmp;
    reset_n = 1'b1;
    we_v    = '0;
    dbus    = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_line%0d", i), so_v[i], 1'b1);
      chk($sformatf("rst_busy%0d", i), busy_v[i], 1'b0);
      chk($sformatf("rst_ovf%0d", i), ovf_v[i], 1'b0);
      chk($sformatf("rst_full%0d", i), full_v[i], 1'b0);
      chk($sformatf("rst_count%0d", i), cnt_of(i), 0);
    end
    reset_n = 1'b1;

    // 8N1, 0x55: start on cycles 2..11, alternating data, busy drops at 102
    wr_data[0] = 8'h55; fr_data[0] = 8'h55;
    cnt_exp[0] = 1; cnt_exp[1] = 0; cnt_exp[2] = 0;
    run_frames("n81", 0, 1, 1, 8, 0, 1, 16, 3, 1_000_000, 106);

    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    wr_data[0] = 8'h07; fr_data[0] = 8'h07;
    cnt_exp[0] = 1; cnt_exp[1] = 0;
    run_frames("e81", 1, 1, 1, 8, 2, 1, 16, 2, 1_000_000, 115);
    run_frames("o81", 2, 1, 1, 8, 1, 1, 16, 2, 1_000_000, 115);

    // DEPTH=4: six back-to-back writes, sixth dropped, five gap-free frames
    wr_data[0] = 8'hA1; wr_data[1] = 8'hB2; wr_data[2] = 8'hC3;
    wr_data[3] = 8'hD4; wr_data[4] = 8'hE5; wr_data[5] = 8'hF6;
    for (int i = 0; i < 5; i++) fr_data[i] = wr_data[i];
    cnt_exp[0] = 1; cnt_exp[1] = 1; cnt_exp[2] = 2;
    cnt_exp[3] = 3; cnt_exp[4] = 4; cnt_exp[5] = 4;
    run_frames("d4", 3, 6, 5, 8, 0, 1, 4, 6, 5, 510);

    // 7O2: 0x7F then 0x01 chained with two stop bits between
    wr_data[0] = 8'h7F; wr_data[1] = 8'h01;
    fr_data[0] = 8'h7F; fr_data[1] = 8'h01;
    cnt_exp[0] = 1; cnt_exp[1] = 1; cnt_exp[2] = 1;
    run_frames("o72", 4, 2, 2, 7, 1, 2, 16, 3, 1_000_000, 230);

    // reset in the middle of a data bit that is driving 0, with a byte still queued
    @(negedge clk); dbus = 8'h3C; we_v[0] = 1'b1;
    @(negedge clk); dbus = 8'h99;
    @(negedge clk); we_v[0] = 1'b0;
    repeat (24) @(negedge clk);
    chk("pre_rst_line", so_v[0], 1'b0);
    chk("pre_rst_count", cnt_of(0), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_line", so_v[0], 1'b1);
    chk("mid_rst_count", cnt_of(0), 0);
    chk("mid_rst_busy", busy_v[0], 1'b0);
    chk("mid_rst_ovf", ovf_v[0], 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    wr_data[0] = 8'hA5; fr_data[0] = 8'hA5;
    cnt_exp[0] = 1; cnt_exp[1] = 0;
    run_frames("post_rst", 0, 1, 1, 8, 0, 1, 16, 2, 1_000_000, 110);

    // random stream: a burst that overfills the FIFO, then sparse writes
    m_cnt = 0; m_edge = 0; m_free = 0; m_drop = 1'b0;
    rx_en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      rnd_step(1'b1, 8'($urandom));
      gap = (i < 24) ? 0 : int'($urandom_range(0, 150));
      for (int g = 0; g < gap; g++) rnd_step(1'b0, 8'h00);
    end
    rnd_step(1'b0, 8'h00);
    for (int t = 0; t < 3000 && busy_v[0]; t++) @(negedge clk);
    chk("rnd_drain_busy", busy_v[0], 1'b0);
    repeat (5) @(negedge clk);
    rx_en = 1'b0;
    chk("rnd_nbytes", rx_q.size(), exp_q.size());
    nb_cmp = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < nb_cmp; i++) chk($sformatf("rnd_byte%0d", i), rx_q[i], exp_q[i]);
    chk("rnd_overflow", ovf_v[0], m_drop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
